// File: rtl/ade_pkt_counter.sv
// Counts audio packets (PKT_LEN ade beats each) per video line and reports the
// per-line total when the line closes, with short-packet and saturation flags.
module ade_pkt_counter #(
    parameter int PKT_LEN    = 32,
    parameter int CNT_W      = 4,
    parameter int LATCH_HCNT = 1447
) (
    input  logic             fifo_clk,
    input  logic             sys_rst,
    input  logic             video_en,
    input  logic             vde,
    input  logic             ade,
    input  logic [10:0]      hcnt,
    output logic [CNT_W-1:0] ade_num,
    output logic             num_valid,
    output logic             pkt_start,
    output logic             pkt_err,
    output logic             ovf,
    output logic             armed
);
    localparam int              BW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0]   BEAT_ONE = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [10:0]     LATCH    = 11'(LATCH_HCNT);

    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] ade_num_q, ade_num_d;
    logic             num_valid_q, pkt_start_q, pkt_err_q, ovf_q, ovf_d;
    logic             armed_q, armed_d, vde_b_q;
    logic             start, err, close, sat;

    always_comb begin
        start     = armed_q & ade & (beat_q == '0);
        err       = armed_q & ~ade & (beat_q != '0);
        close     = armed_q & ((~video_en & (hcnt == LATCH)) | (vde & ~vde_b_q));
        sat       = (cnt_q == CNT_MAX);
        // A packet starting on the closing cycle belongs to the line being closed.
        cnt_inc   = (start & ~sat) ? cnt_q + CNT_ONE : cnt_q;
        cnt_d     = close ? '0 : cnt_inc;
        ade_num_d = close ? cnt_inc : ade_num_q;
        ovf_d     = ovf_q | (start & sat);
        armed_d   = armed_q | video_en;
        // Beat position tracks ade even while unarmed; any gap realigns to 0.
        beat_d    = ade ? beat_q + BEAT_ONE : '0;
    end

    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            beat_q      <= '0;
            cnt_q       <= '0;
            ade_num_q   <= '0;
            num_valid_q <= 1'b0;
            pkt_start_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            armed_q     <= 1'b0;
            vde_b_q     <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            ade_num_q   <= ade_num_d;
            num_valid_q <= close;
            pkt_start_q <= start;
            pkt_err_q   <= err;
            ovf_q       <= ovf_d;
            armed_q     <= armed_d;
            vde_b_q     <= vde;
        end
    end

    assign ade_num   = ade_num_q;
    assign num_valid = num_valid_q;
    assign pkt_start = pkt_start_q;
    assign pkt_err   = pkt_err_q;
    assign ovf       = ovf_q;
    assign armed     = armed_q;
endmodule

// File: tb/tb_ade_pkt_counter.sv
// Directed scenarios then random traffic, every cycle compared against a
// per-line packet-tally model.
module tb_ade_pkt_counter;
    localparam int PKT_LEN = 32;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int LATCH   = 1447;

    logic             fifo_clk = 1'b0;
    logic             sys_rst, video_en, vde, ade;
    logic [10:0]      hcnt;
    logic [CNT_W-1:0] ade_num;
    logic             num_valid, pkt_start, pkt_err, ovf, armed;

    int errors = 0;
    int checks = 0;

    // model state: position inside the current burst, packets seen this line (unsaturated)
    int m_pos, m_pkts, m_num;
    bit m_armed, m_vdeb, m_nv, m_ps, m_pe, m_ovf;

    ade_pkt_counter #(.PKT_LEN(PKT_LEN), .CNT_W(CNT_W), .LATCH_HCNT(LATCH)) dut (
        .fifo_clk(fifo_clk), .sys_rst(sys_rst), .video_en(video_en), .vde(vde),
        .ade(ade), .hcnt(hcnt), .ade_num(ade_num), .num_valid(num_valid),
        .pkt_start(pkt_start), .pkt_err(pkt_err), .ovf(ovf), .armed(armed)
    );

    always #5 fifo_clk = ~fifo_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit start, err, close;
        if (sys_rst) begin
            m_pos = 0; m_pkts = 0; m_num = 0; m_armed = 0; m_vdeb = 0;
            m_nv = 0; m_ps = 0; m_pe = 0; m_ovf = 0;
        end else begin
            start = m_armed && ade && (m_pos == 0);
            err   = m_armed && !ade && (m_pos != 0);
            close = m_armed && ((!video_en && int'(hcnt) == LATCH) || (vde && !m_vdeb));
            if (start) m_pkts++;
            if (m_pkts > MAXC) m_ovf = 1;
            m_nv = close;
            if (close) begin
                m_num  = (m_pkts > MAXC) ? MAXC : m_pkts;
                m_pkts = 0;
            end
            m_ps    = start;
            m_pe    = err;
            m_pos   = ade ? (m_pos + 1) % PKT_LEN : 0;
            m_armed = m_armed || video_en;
            m_vdeb  = vde;
        end
    endtask

    task automatic step(input bit r, input bit ven, input bit v, input bit a, input int h);
        sys_rst = r; video_en = ven; vde = v; ade = a; hcnt = 11'(h);
        @(posedge fifo_clk);
        model_update();
        #1;
        chk("ade_num",   int'(ade_num),   m_num);
        chk("num_valid", int'(num_valid), int'(m_nv));
        chk("pkt_start", int'(pkt_start), int'(m_ps));
        chk("pkt_err",   int'(pkt_err),   int'(m_pe));
        chk("ovf",       int'(ovf),       int'(m_ovf));
        chk("armed",     int'(armed),     int'(m_armed));
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic close_hcnt();
        step(0, 0, 0, 0, LATCH);
    endtask

    initial begin
        int starts;
        bit r_ven, r_vde, r_ade;
        int r_h;
        sys_rst = 1; video_en = 0; vde = 0; ade = 0; hcnt = '0;

        // reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_ade_num", int'(ade_num), 0);
        chk("reset_armed", int'(armed), 0);

        // ade before arming: nothing counted, close ignored
        burst(40);
        close_hcnt();
        chk("unarmed_num", int'(ade_num), 0);
        chk("unarmed_nv", int'(num_valid), 0);

        // arm, three full packets in blanking, close on hcnt
        step(0, 1, 0, 0, 0);
        chk("armed_set", int'(armed), 1);
        starts = 0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i <= PKT_LEN; i++) begin
                step(0, 0, 0, i < PKT_LEN, 0);
                if (i == 0) starts += int'(pkt_start);
            end
        chk("three_starts", starts, 3);
        close_hcnt();
        chk("three_num", int'(ade_num), 3);
        chk("three_nv", int'(num_valid), 1);
        step(0, 0, 0, 0, 0);
        chk("nv_one_cycle", int'(num_valid), 0);

        // short packet then a full one
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("short_err", int'(pkt_err), 1);
        step(0, 0, 0, 1, 0);
        chk("after_err_start", int'(pkt_start), 1);
        for (int i = 1; i < PKT_LEN; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        close_hcnt();
        chk("short_num", int'(ade_num), 2);

        // 17 packets saturate the line count
        for (int p = 0; p < 17; p++) burst(PKT_LEN);
        close_hcnt();
        chk("sat_num", int'(ade_num), MAXC);
        chk("sat_ovf", int'(ovf), 1);
        close_hcnt();
        chk("ovf_sticky", int'(ovf), 1);
        chk("empty_line", int'(ade_num), 0);

        // packet start on the vde rising edge goes into the closing line
        burst(PKT_LEN);
        step(0, 0, 1, 1, 0);
        chk("vde_close_nv", int'(num_valid), 1);
        chk("vde_close_num", int'(ade_num), 2);
        for (int i = 1; i < PKT_LEN; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        close_hcnt();
        chk("next_line_zero", int'(ade_num), 0);

        // reset at beat 10
        burst(PKT_LEN);
        close_hcnt();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_num", int'(ade_num), 0);
        step(0, 0, 0, 0, 0);
        chk("rst_no_err", int'(pkt_err), 0);
        burst(PKT_LEN);
        close_hcnt();
        chk("rearm_needed", int'(ade_num), 0);
        step(0, 1, 0, 0, 0);

        // random traffic
        r_ven = 0; r_vde = 0; r_ade = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) r_vde = ~r_vde;
            if (r_ade) begin
                if ($urandom_range(0, 39) == 0) r_ade = 0;
            end else if ($urandom_range(0, 5) == 0) r_ade = 1;
            r_ven = ($urandom_range(0, 99) == 0);
            r_h = ($urandom_range(0, 59) == 0) ? LATCH : int'($urandom_range(0, 1446));
            step($urandom_range(0, 999) == 0, r_ven, r_vde, r_ade, r_h);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ade_pkt_counter.md
ADE_PKT_COUNTER -- requirements
Module: ade_pkt_counter

Interface
REQ-001 Parameter PKT_LEN, default 32, meaning ADE cycles per audio packet (power of two, 2..256).
REQ-002 Parameter CNT_W, default 4, meaning width of the per-line packet count.
REQ-003 Parameter LATCH_HCNT, default 1447, meaning the blanking hcnt value that closes a line.
REQ-004 Port fifo_clk, input, 1, meaning the pixel clock; the only clock of the block.
REQ-005 Port sys_rst, input, 1, meaning reset, synchronous, active-high.
REQ-006 Port video_en, input, 1, meaning the active-video indication from the timing block.
REQ-007 Port vde, input, 1, meaning the video data enable used for rising-edge line detection.
REQ-008 Port ade, input, 1, meaning the audio data enable, high for each audio beat.
REQ-009 Port hcnt, input, 11, meaning the horizontal counter.
REQ-010 Port ade_num, output, CNT_W, meaning the packet count of the last closed line.
REQ-011 Port num_valid, output, 1, meaning a one-cycle strobe when ade_num updates.
REQ-012 Port pkt_start, output, 1, meaning a one-cycle strobe on the first beat of each packet.
REQ-013 Port pkt_err, output, 1, meaning a one-cycle strobe when a packet ends short.
REQ-014 Port ovf, output, 1, meaning a sticky flag set when the running count saturates.
REQ-015 Port armed, output, 1, meaning counting is enabled.

Function
REQ-016 armed SHALL be set one cycle after the first cycle with video_en=1 and SHALL stay set until reset.
REQ-017 The block SHALL keep a beat counter of log2(PKT_LEN) bits that increments on each ade=1 cycle and wraps from PKT_LEN-1 to 0.
REQ-018 The block SHALL assert pkt_start, registered one cycle later, when ade=1 with beat counter 0 and armed=1.
REQ-019 A running count (CNT_W bits) SHALL increment on each pkt_start condition and saturate at 2^CNT_W-1.
REQ-020 An increment attempted at saturation SHALL set ovf.
REQ-021 vde_b SHALL be vde delayed one cycle; the line close condition SHALL be armed & ((~video_en & hcnt==LATCH_HCNT) | (vde & ~vde_b)).
REQ-022 On line close, ade_num SHALL load the running count, including any packet started in the same cycle, with num_valid high the next cycle.
REQ-023 On line close, the running count SHALL restart at 0.
REQ-024 A line close and a packet start in the same cycle SHALL load ade_num with count+1 (saturating) and restart the running count at 0, so no packet is lost.
REQ-025 If ade falls while the beat counter is non-zero, pkt_err SHALL pulse one cycle later and the beat counter SHALL return to 0.
REQ-026 The partial packet SHALL remain counted.
REQ-027 When armed=0, the running count SHALL stay 0, pkt_start SHALL stay 0 and pkt_err SHALL stay 0.
REQ-028 When armed=0, the beat counter SHALL still track ade.
REQ-029 All outputs SHALL be registered; latency from stimulus edge to output SHALL be 1 cycle.

Reset
REQ-030 While sys_rst=1 at a fifo_clk edge, ade_num, num_valid, pkt_start, pkt_err, ovf, armed, the beat counter, the running count and vde_b SHALL clear to 0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet without a pkt_err pulse.
REQ-032 After reset, counting SHALL resume only once armed is set again.

Verification
REQ-033 Defaults; video_en pulse; three 32-cycle ade bursts in blanking; hcnt reaches 1447 with video_en=0 -> three pkt_start pulses, then ade_num=3 with num_valid for 1 cycle.
REQ-034 ade high for 20 cycles then low -> pkt_err 1 cycle after the fall; the next burst gives pkt_start at its first beat; that line closes with ade_num=2.
REQ-035 CNT_W=4; 17 full packets in one line -> ade_num=15 and ovf=1, with ovf still 1 after the next line close.
REQ-036 The first beat of a packet coincides with the vde rising edge -> ade_num includes that packet and the next line starts at count 0.
REQ-037 ade bursts before any video_en -> no pkt_start and ade_num stays 0; after arming, normal counting.
REQ-038 sys_rst asserted at beat 10 of a packet -> all outputs 0 the next cycle, no pkt_err, armed=0.
